pipe_ex_mem: RTL and testbench
==============================

Name: pipe_ex_mem

Overview:
- Parametrised EX/MEM pipeline register for the MIPS core. Sits between the execute stage and the memory-access stage.
- Carries the GPR write-back bundle and the HI/LO write bundle forward.
- Carries multi-cycle (madd/msub/div) accumulator and counter state back to EX while EX is stalled.
- Beyond the previous generation, it adds:
  - generic data, address and counter widths
  - a selectable stall-vector position
  - a valid bit with write-enable qualification
  - a synchronous flush
  - a saturating stall-duration monitor

Parameters:
- DATA_W, 32, width of the GPR data and of each of HI and LO
- ADDR_W, 5, width of the destination register address
- CNT_W, 2, width of the multi-cycle step counter
- STALL_W, 6, width of the stall vector from the stall controller
- STAGE, 3, index of this stage's upstream (EX) stall bit; STAGE+1 is the downstream (MEM) bit; legal range 0..STALL_W-2
- HOLD_W, 8, width of the stall-duration counter

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous flush (exception/branch kill)
- stall_en  input  STALL_W  stall vector from the stall controller
- in_valid  input  1  EX result is a real instruction
- in_addr  input  ADDR_W  GPR destination
- in_wen  input  1  GPR write enable
- in_data  input  DATA_W  GPR write data
- in_hilo_wen  input  1  HI/LO write enable
- in_hi  input  DATA_W  HI write value
- in_lo  input  DATA_W  LO write value
- in_acc  input  2*DATA_W  multi-cycle partial result from EX
- in_cnt  input  CNT_W  multi-cycle step count from EX
- out_valid  output  1  registered valid
- out_addr  output  ADDR_W  registered GPR destination
- out_wen  output  1  registered GPR write enable
- out_data  output  DATA_W  registered GPR data
- out_hilo_wen  output  1  registered HI/LO write enable
- out_hi  output  DATA_W  registered HI
- out_lo  output  DATA_W  registered LO
- out_acc  output  2*DATA_W  accumulator fed back to EX
- out_cnt  output  CNT_W  step count fed back to EX
- hold_cnt  output  HOLD_W  consecutive non-advance cycles, saturating
- hold_sat  output  1  hold_cnt equals all-ones

Behaviour:
- Reset:
  - reset low clears every output to 0 immediately, without waiting for clk.
  - Deassertion is sampled on the next rising edge; the first edge with reset high evaluates the modes below normally.
- Define up = stall_en[STAGE] and dn = stall_en[STAGE+1].
- Mode priority per edge is fixed as follows; exactly one mode applies.
  1. FLUSH (flush=1):
     - Payload outputs 0, out_valid 0.
     - out_acc and out_cnt 0: flush aborts any multi-cycle operation.
     - hold_cnt 0.
  2. BUBBLE (up=1, dn=0):
     - Payload outputs 0 and out_valid 0; a NOP enters MEM.
     - out_acc<=in_acc, out_cnt<=in_cnt.
     - hold_cnt increments.
  3. ADVANCE (up=0):
     - out_valid<=in_valid, out_addr<=in_addr, out_data<=in_data, out_hi<=in_hi, out_lo<=in_lo.
     - out_wen<=in_wen&in_valid, out_hilo_wen<=in_hilo_wen&in_valid.
     - out_acc and out_cnt 0.
     - hold_cnt 0.
     - dn is ignored when up=0.
  4. HOLD (up=1, dn=1):
     - Payload and out_valid retain their values.
     - out_acc<=in_acc, out_cnt<=in_cnt.
     - hold_cnt increments.
- hold_cnt:
  - Saturates at 2^HOLD_W-1; there is no wrap.
  - hold_sat is combinational from hold_cnt.
- Latency:
  - Input to output is one cycle in ADVANCE.
  - Accumulator feedback is one cycle in BUBBLE or HOLD.
- The write-enable qualification means a non-valid advance can never write the GPR or HI/LO, even with in_wen=1.
- Flush during HOLD or BUBBLE wins: valid drops and the accumulator clears on that edge.
- Reset asserted mid multi-cycle operation clears the accumulator; EX restarts from step 0.
- Outputs depend only on registered state; there is no combinational path from input to output except hold_sat from hold_cnt.

Test Plan:
- Reset then advance:
  - Hold reset low and check all outputs are 0 before any clk edge.
  - Release reset, apply in_valid=1, in_addr=5'd9, in_wen=1, in_data=32'hDEADBEEF, stall_en=0.
  - Next edge: out_addr=9, out_wen=1, out_data=DEADBEEF, out_valid=1, out_acc=0.
- Invalid advance:
  - Apply in_valid=0, in_wen=1, in_hilo_wen=1, in_hi=32'h1, stall_en=0.
  - Required: out_valid=0, out_wen=0, out_hilo_wen=0, out_hi=1.
- Bubble with feedback:
  - Apply stall_en=6'b001000, in_acc=64'h0000_0001_0000_0002, in_cnt=2'b01.
  - Required: payload outputs 0, out_acc=64'h0000_0001_0000_0002, out_cnt=1, hold_cnt=1.
  - Then stall_en=0: out_acc=0, out_cnt=0, hold_cnt=0.
- Hold:
  - Load out_data=32'hA5A5A5A5, then apply stall_en=6'b011000 for 3 cycles with in_data=32'h0 and in_cnt=2,3,0.
  - Required: out_data stays A5A5A5A5 and out_valid is unchanged; out_cnt tracks 2,3,0 one cycle late; hold_cnt=3.
- Flush priority:
  - During HOLD, pulse flush=1 for one cycle.
  - Required: out_valid=0, out_wen=0, out_acc=0, out_cnt=0, hold_cnt=0 on that edge.
- Saturation and async reset:
  - With HOLD_W=3, hold stall_en=6'b011000 for 10 cycles.
  - Required: hold_cnt reaches 7 after 7 cycles and stays there; hold_sat=1.
  - Assert reset low mid-cycle: all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/pipe_ex_mem_if.sv
// EX/MEM pipeline register bundle: EX-side inputs, MEM-side outputs and the
// multi-cycle feedback path back to EX.
interface pipe_ex_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int HOLD_W  = 8
);
  logic                flush;
  logic [STALL_W-1:0]  stall_en;
  logic                in_valid;
  logic [ADDR_W-1:0]   in_addr;
  logic                in_wen;
  logic [DATA_W-1:0]   in_data;
  logic                in_hilo_wen;
  logic [DATA_W-1:0]   in_hi;
  logic [DATA_W-1:0]   in_lo;
  logic [2*DATA_W-1:0] in_acc;
  logic [CNT_W-1:0]    in_cnt;

  logic                out_valid;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_wen;
  logic [DATA_W-1:0]   out_data;
  logic                out_hilo_wen;
  logic [DATA_W-1:0]   out_hi;
  logic [DATA_W-1:0]   out_lo;
  logic [2*DATA_W-1:0] out_acc;
  logic [CNT_W-1:0]    out_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_sat;

  modport master (
    output flush, stall_en, in_valid, in_addr, in_wen, in_data,
           in_hilo_wen, in_hi, in_lo, in_acc, in_cnt,
    input  out_valid, out_addr, out_wen, out_data, out_hilo_wen,
           out_hi, out_lo, out_acc, out_cnt, hold_cnt, hold_sat
  );

  modport slave (
    input  flush, stall_en, in_valid, in_addr, in_wen, in_data,
           in_hilo_wen, in_hi, in_lo, in_acc, in_cnt,
    output out_valid, out_addr, out_wen, out_data, out_hilo_wen,
           out_hi, out_lo, out_acc, out_cnt, hold_cnt, hold_sat
  );
endinterface

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register with flush, bubble/hold stall handling, multi-cycle
// accumulator feedback to EX and a saturating stall-duration counter.
module pipe_ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int HOLD_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  pipe_ex_mem_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_FLUSH
  } mode_e;

  mode_e mode;
  logic  up, dn;
  logic  unused_stall;

  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hilo_wen_q, hilo_wen_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d, hold_inc;

  assign up           = bus.stall_en[STAGE];
  assign dn           = bus.stall_en[STAGE+1];
  assign unused_stall = ^bus.stall_en;

  // Flush outranks any stall; dn only matters while EX itself is stalled.
  always_comb begin
    mode = MODE_ADVANCE;
    if (bus.flush)  mode = MODE_FLUSH;
    else if (!up)   mode = MODE_ADVANCE;
    else if (!dn)   mode = MODE_BUBBLE;
    else            mode = MODE_HOLD;
  end

  assign hold_inc = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    data_d     = data_q;
    hilo_wen_d = hilo_wen_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    case (mode)
      MODE_FLUSH: begin
        valid_d    = 1'b0;
        addr_d     = '0;
        wen_d      = 1'b0;
        data_d     = '0;
        hilo_wen_d = 1'b0;
        hi_d       = '0;
        lo_d       = '0;
        acc_d      = '0;
        cnt_d      = '0;
        hold_d     = '0;
      end
      MODE_BUBBLE: begin
        valid_d    = 1'b0;
        addr_d     = '0;
        wen_d      = 1'b0;
        data_d     = '0;
        hilo_wen_d = 1'b0;
        hi_d       = '0;
        lo_d       = '0;
        acc_d      = bus.in_acc;
        cnt_d      = bus.in_cnt;
        hold_d     = hold_inc;
      end
      MODE_ADVANCE: begin
        valid_d    = bus.in_valid;
        addr_d     = bus.in_addr;
        wen_d      = bus.in_wen & bus.in_valid;
        data_d     = bus.in_data;
        hilo_wen_d = bus.in_hilo_wen & bus.in_valid;
        hi_d       = bus.in_hi;
        lo_d       = bus.in_lo;
        acc_d      = '0;
        cnt_d      = '0;
        hold_d     = '0;
      end
      MODE_HOLD: begin
        acc_d  = bus.in_acc;
        cnt_d  = bus.in_cnt;
        hold_d = hold_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      data_q     <= '0;
      hilo_wen_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
      hilo_wen_q <= hilo_wen_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_addr     = addr_q;
  assign bus.out_wen      = wen_q;
  assign bus.out_data     = data_q;
  assign bus.out_hilo_wen = hilo_wen_q;
  assign bus.out_hi       = hi_q;
  assign bus.out_lo       = lo_q;
  assign bus.out_acc      = acc_q;
  assign bus.out_cnt      = cnt_q;
  assign bus.hold_cnt     = hold_q;
  assign bus.hold_sat     = (hold_q == '1);

endmodule

// File: tb/tb_pipe_ex_mem.sv
// Directed table-driven bench for pipe_ex_mem, built with a 3-bit hold counter
// so saturation is reachable in a few cycles.
module tb_pipe_ex_mem;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int HOLD_W  = 3;

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic        v;
    logic [4:0]  a;
    logic        w;
    logic [31:0] d;
    logic        hw;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] acc;
    logic [1:0]  cnt;
    logic        xv;
    logic [4:0]  xa;
    logic        xw;
    logic [31:0] xd;
    logic        xhw;
    logic [31:0] xhi;
    logic [31:0] xlo;
    logic [63:0] xacc;
    logic [1:0]  xcnt;
    logic [2:0]  xhold;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;
  vec_t tv[13];
  vec_t e;

  pipe_ex_mem_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .HOLD_W(HOLD_W)
  ) bus ();

  pipe_ex_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .STALL_W(STALL_W), .STAGE(STAGE), .HOLD_W(HOLD_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t x);
    chk({tag, " out_valid"},    64'(bus.out_valid),    64'(x.xv));
    chk({tag, " out_addr"},     64'(bus.out_addr),     64'(x.xa));
    chk({tag, " out_wen"},      64'(bus.out_wen),      64'(x.xw));
    chk({tag, " out_data"},     64'(bus.out_data),     64'(x.xd));
    chk({tag, " out_hilo_wen"}, 64'(bus.out_hilo_wen), 64'(x.xhw));
    chk({tag, " out_hi"},       64'(bus.out_hi),       64'(x.xhi));
    chk({tag, " out_lo"},       64'(bus.out_lo),       64'(x.xlo));
    chk({tag, " out_acc"},      bus.out_acc,           x.xacc);
    chk({tag, " out_cnt"},      64'(bus.out_cnt),      64'(x.xcnt));
    chk({tag, " hold_cnt"},     64'(bus.hold_cnt),     64'(x.xhold));
    chk({tag, " hold_sat"},     64'(bus.hold_sat),     64'(x.xhold == 3'd7));
  endtask

  task automatic drive(input vec_t x);
    bus.flush       = x.flush;
    bus.stall_en    = x.stall;
    bus.in_valid    = x.v;
    bus.in_addr     = x.a;
    bus.in_wen      = x.w;
    bus.in_data     = x.d;
    bus.in_hilo_wen = x.hw;
    bus.in_hi       = x.hi;
    bus.in_lo       = x.lo;
    bus.in_acc      = x.acc;
    bus.in_cnt      = x.cnt;
  endtask

  task automatic apply(input string tag, input vec_t x);
    drive(x);
    @(posedge clk);
    #1;
    check_out(tag, x);
    @(negedge clk);
  endtask

  initial begin
    vec_t z;
    n_checks = 0;
    n_err    = 0;
    z = '{default: '0};

    //        flush stall      v a      w d             hw hi      lo      acc                     cnt
    //        xv xa     xw xd             xhw xhi     xlo      xacc                    xcnt xhold
    tv[0]  = '{0, 6'b000000, 1, 5'd9,  1, 32'hDEADBEEF, 0, 32'h0,  32'h0,  64'h0,                  2'd0,
               1, 5'd9,  1, 32'hDEADBEEF, 0, 32'h0,  32'h0,  64'h0,                  2'd0, 3'd0};
    tv[1]  = '{0, 6'b000000, 0, 5'd3,  1, 32'h00001234, 1, 32'h1,  32'h0,  64'h0,                  2'd0,
               0, 5'd3,  0, 32'h00001234, 0, 32'h1,  32'h0,  64'h0,                  2'd0, 3'd0};
    tv[2]  = '{0, 6'b001000, 1, 5'd4,  1, 32'h00005555, 1, 32'h2,  32'h3,  64'h0000_0001_0000_0002, 2'd1,
               0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h0000_0001_0000_0002, 2'd1, 3'd1};
    tv[3]  = '{0, 6'b000000, 1, 5'd7,  1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'hFFFF,               2'd3,
               1, 5'd7,  1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h0,                  2'd0, 3'd0};
    tv[4]  = '{0, 6'b011000, 0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h10,                 2'd2,
               1, 5'd7,  1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h10,                 2'd2, 3'd1};
    tv[5]  = '{0, 6'b011000, 0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h20,                 2'd3,
               1, 5'd7,  1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h20,                 2'd3, 3'd2};
    tv[6]  = '{0, 6'b011000, 0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h30,                 2'd0,
               1, 5'd7,  1, 32'hA5A5A5A5, 1, 32'h11, 32'h22, 64'h30,                 2'd0, 3'd3};
    tv[7]  = '{1, 6'b011000, 1, 5'd8,  1, 32'h99,       1, 32'h5,  32'h6,  64'h40,                 2'd1,
               0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h0,                  2'd0, 3'd0};
    tv[8]  = '{0, 6'b010000, 1, 5'd31, 0, 32'hFFFFFFFF, 1, 32'hAAAA, 32'h5555, 64'h50,             2'd2,
               1, 5'd31, 0, 32'hFFFFFFFF, 1, 32'hAAAA, 32'h5555, 64'h0,              2'd0, 3'd0};
    tv[9]  = '{1, 6'b000000, 1, 5'd1,  1, 32'h1,        1, 32'h1,  32'h1,  64'h1,                  2'd1,
               0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h0,                  2'd0, 3'd0};
    tv[10] = '{0, 6'b101111, 1, 5'd6,  1, 32'h66,       1, 32'h7,  32'h8,  64'hFEDC_BA98_7654_3210, 2'd2,
               0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'hFEDC_BA98_7654_3210, 2'd2, 3'd1};
    tv[11] = '{0, 6'b011000, 1, 5'd6,  1, 32'h66,       1, 32'h7,  32'h8,  64'h0123,               2'd3,
               0, 5'd0,  0, 32'h0,        0, 32'h0,  32'h0,  64'h0123,               2'd3, 3'd2};
    tv[12] = '{0, 6'b000111, 1, 5'd12, 1, 32'h00C0FFEE, 0, 32'h0,  32'h9,  64'h77,                 2'd1,
               1, 5'd12, 1, 32'h00C0FFEE, 0, 32'h0,  32'h9,  64'h0,                  2'd0, 3'd0};

    // Asynchronous reset visible before any clock edge.
    reset = 1'b0;
    drive(tv[0]);
    #2;
    check_out("reset", z);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply($sformatf("vec%0d", i), tv[i]);
    end

    // Long hold: counter saturates at 7 and stays there, payload retained.
    e = tv[12];
    e.stall = 6'b011000;
    e.v     = 1'b0;
    e.w     = 1'b1;
    e.d     = 32'h0;
    e.acc   = 64'h1234;
    e.cnt   = 2'd1;
    e.xacc  = 64'h1234;
    e.xcnt  = 2'd1;
    for (int k = 1; k <= 10; k++) begin
      e.xhold = (k >= 7) ? 3'd7 : 3'(k);
      apply($sformatf("sat%0d", k), e);
    end

    // Reset asserted mid-cycle clears everything without a clock edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_out("midreset", z);
    @(negedge clk);
    reset = 1'b1;
    apply("post_reset", tv[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
